// File: rtl/ntt_dout_unload_pkg.sv
// Shared constants and FSM state type for the NTT output unload path.
package ntt_pkg;

  localparam int unsigned Q          = 3329;
  localparam int unsigned DATA_WIDTH = 13;
  localparam int unsigned OUT_WIDTH  = 12;
  localparam int unsigned LANES      = 16;
  localparam int unsigned BEATS      = 16;
  localparam int unsigned ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ntt_dout_unload_if.sv
// Coefficient-memory read port and packed output stream of the unload block.
interface ntt_dout_unload_if #(
  parameter int unsigned DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = ntt_pkg::OUT_WIDTH,
  parameter int unsigned LANES      = ntt_pkg::LANES
);
  logic                          rd_en_o;
  logic [ntt_pkg::ADDR_WIDTH-1:0] rd_addr_o;
  logic [LANES*DATA_WIDTH-1:0]   rd_data_i;
  logic [LANES*OUT_WIDTH-1:0]    dout;
  logic                          valid_output;
  logic                          ready_i;

  modport master (
    output rd_en_o, rd_addr_o, dout, valid_output,
    input  rd_data_i, ready_i
  );

  modport slave (
    input  rd_en_o, rd_addr_o, dout, valid_output,
    output rd_data_i, ready_i
  );
endinterface

// File: rtl/ntt_dout_unload_reduce.sv
// Single-lane conditional subtract of Q; NTT_UNLOAD_REDUCE_EN compiles the
// reduction in, otherwise the lane passes its low OUT_WIDTH bits through.
module coeff_reduce_q #(
  parameter int unsigned DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = ntt_pkg::OUT_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [OUT_WIDTH-1:0]  dout
);
  import ntt_pkg::*;

  logic [DATA_WIDTH-1:0] red;
  logic                  unused_msb;

`ifdef NTT_UNLOAD_REDUCE_EN
  assign red = (din >= DATA_WIDTH'(Q)) ? din - DATA_WIDTH'(Q) : din;
`else
  assign red = din;
`endif

  assign dout       = red[OUT_WIDTH-1:0];
  assign unused_msb = ^red[DATA_WIDTH-1:OUT_WIDTH];
endmodule

// File: rtl/ntt_dout_unload.sv
// Streams one polynomial out of coefficient memory through a 2-entry skid
// buffer, reducing each lane mod Q when NTT_UNLOAD_REDUCE_EN is defined.
module ntt_dout_unload #(
  parameter int unsigned DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = ntt_pkg::OUT_WIDTH,
  parameter int unsigned LANES      = ntt_pkg::LANES,
  parameter int unsigned BEATS      = ntt_pkg::BEATS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_unload,
  output logic busy_o,
  output logic done_o,
  ntt_dout_unload_if.master bus
);
  import ntt_pkg::*;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [ADDR_WIDTH-1:0]      beat_q;
  logic                       inflight_q;
  logic [1:0]                 occ_q;
  logic                       wr_ptr_q, rd_ptr_q;
  logic [LANES*OUT_WIDTH-1:0] buf_q [2];
  logic [LANES*OUT_WIDTH-1:0] reduced;
  logic                       pop, rd_en, last_addr, last_beat;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    coeff_reduce_q #(
      .DATA_WIDTH(DATA_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_reduce (
      .din (bus.rd_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .dout(reduced[k*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  assign pop       = (occ_q != '0) && bus.ready_i;
  assign last_addr = (addr_q == ADDR_WIDTH'(BEATS - 1));
  assign last_beat = (beat_q == ADDR_WIDTH'(BEATS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Occupancy plus in-flight read, minus this cycle's pop, stays <= 2 after
  // every edge, so a read is only issued when its data has a slot waiting.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: if (start_unload) state_d = READ;
      READ: begin
        busy_o = 1'b1;
        if (({1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2) rd_en = 1'b1;
        if (rd_en && last_addr) state_d = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (pop && last_beat) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) buf_q[i] <= '0;
    end else begin
      inflight_q <= rd_en;
      if (state_q == IDLE && start_unload) begin
        addr_q <= '0;
        beat_q <= '0;
      end else begin
        if (rd_en && !last_addr) addr_q <= addr_q + 1'b1;
        if (pop) beat_q <= beat_q + 1'b1;
      end
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= reduced;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign bus.rd_en_o      = rd_en;
  assign bus.rd_addr_o    = addr_q;
  assign bus.dout         = buf_q[rd_ptr_q];
  assign bus.valid_output = (occ_q != '0);
endmodule

// File: tb/tb_ntt_dout_unload.sv
// Directed bench for ntt_dout_unload; expectations follow NTT_UNLOAD_REDUCE_EN.
module tb_ntt_dout_unload;
  localparam int DW = 13;
  localparam int OW = 12;
  localparam int NL = 16;
  localparam int NB = 16;

  typedef struct {
    logic [12:0] lane_in;
    logic [11:0] exp_red;
    logic [11:0] exp_raw;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_unload = 1'b0;
  logic busy_o, done_o;
  int   n_vec = 0;
  int   n_err = 0;

  logic [NL*DW-1:0] mem     [NB];
  logic [NL*OW-1:0] exp_mem [NB];
  vec_t             tbl     [8];

  ntt_dout_unload_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .LANES(NL)) bus ();

  ntt_dout_unload #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .LANES     (NL),
    .BEATS     (NB)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_unload(start_unload),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Registered coefficient memory: data appears one cycle after rd_en_o.
  always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= mem[bus.rd_addr_o];

  task automatic chk(input string nm, input logic [NL*OW-1:0] act, input logic [NL*OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic setup_count();
    for (int n = 0; n < NB; n++)
      for (int k = 0; k < NL; k++) begin
        mem[n][k*DW +: DW]     = 13'(n);
        exp_mem[n][k*OW +: OW] = 12'(n);
      end
  endtask

  task automatic setup_table();
    for (int n = 0; n < NB; n++)
      for (int k = 0; k < NL; k++) begin
        mem[n][k*DW +: DW] = tbl[(n + k) % 8].lane_in;
`ifdef NTT_UNLOAD_REDUCE_EN
        exp_mem[n][k*OW +: OW] = tbl[(n + k) % 8].exp_red;
`else
        exp_mem[n][k*OW +: OW] = tbl[(n + k) % 8].exp_raw;
`endif
      end
  endtask

  // mode 0: ready high; 1: random ready; 2: ready high plus stray starts;
  // 3: ready high, leave after beat 5 has been presented for acceptance.
  task automatic run_unload(input int mode);
    logic [NL*OW-1:0] got [$];
    logic [NL*OW-1:0] held;
    logic             stall;
    int done_cnt, done_cyc, last_acc, rd_cnt, tail, cyc;
    got = {};
    held = '0;
    stall = 1'b0;
    done_cnt = 0; done_cyc = -1; last_acc = -100; rd_cnt = 0; tail = 0;
    @(negedge clk);
    start_unload = 1'b1;
    bus.ready_i  = 1'b1;
    for (cyc = 1; cyc <= 400 && tail < 6; cyc++) begin
      @(negedge clk);
      start_unload = (mode == 2) && (cyc == 5 || cyc == 9 || done_o);
      bus.ready_i  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (mode != 1 && cyc == 2) chk_i("valid_before_2", int'(bus.valid_output), 0);
      if (mode != 1 && cyc == 3) chk_i("valid_at_2", int'(bus.valid_output), 1);
      if (cyc == 1) chk_i("busy_after_start", int'(busy_o), 1);
      if (stall) begin
        chk_i("stall_valid", int'(bus.valid_output), 1);
        chk("stall_dout", bus.dout, held);
      end
      stall = bus.valid_output && !bus.ready_i;
      held  = bus.dout;
      if (bus.rd_en_o) begin
        chk_i("rd_addr", int'(bus.rd_addr_o), rd_cnt);
        rd_cnt++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0) tail++;
      if (bus.valid_output && bus.ready_i) begin
        got.push_back(bus.dout);
        last_acc = cyc;
        if (mode == 3 && got.size() == 6) break;
      end
    end
    chk_i("beat_count", got.size(), (mode == 3) ? 6 : NB);
    for (int i = 0; i < got.size() && i < NB; i++)
      chk($sformatf("beat%0d", i), got[i], exp_mem[i]);
    if (mode != 3) begin
      chk_i("rd_count", rd_cnt, NB);
      chk_i("done_count", done_cnt, 1);
      chk_i("done_latency", done_cyc, last_acc + 1);
      chk_i("busy_after_done", int'(busy_o), 0);
    end
  endtask

  initial begin
    int stray;
    tbl[0] = '{13'd0,    12'h000, 12'h000};
    tbl[1] = '{13'd3328, 12'hd00, 12'hd00};
    tbl[2] = '{13'd3329, 12'h000, 12'hd01};
    tbl[3] = '{13'd3330, 12'h001, 12'hd02};
    tbl[4] = '{13'd6657, 12'hd00, 12'ha01};
    tbl[5] = '{13'd4095, 12'h2fe, 12'hfff};
    tbl[6] = '{13'd4096, 12'h2ff, 12'h000};
    tbl[7] = '{13'd1,    12'h001, 12'h001};
    bus.ready_i = 1'b0;

    repeat (3) @(negedge clk);
    chk_i("rst_rd_en", int'(bus.rd_en_o), 0);
    chk_i("rst_rd_addr", int'(bus.rd_addr_o), 0);
    chk_i("rst_valid", int'(bus.valid_output), 0);
    chk("rst_dout", bus.dout, '0);
    chk_i("rst_busy", int'(busy_o), 0);
    chk_i("rst_done", int'(done_o), 0);
    rst = 1'b0;

    setup_count();
    run_unload(0);
    setup_table();
    run_unload(1);
    setup_count();
    run_unload(2);

    run_unload(3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk_i("midrst_valid", int'(bus.valid_output), 0);
    chk("midrst_dout", bus.dout, '0);
    chk_i("midrst_rd_en", int'(bus.rd_en_o), 0);
    chk_i("midrst_busy", int'(busy_o), 0);
    chk_i("midrst_done", int'(done_o), 0);
    start_unload = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.ready_i = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (bus.valid_output || bus.rd_en_o || busy_o) stray++;
    end
    chk_i("quiet_after_rst", stray, 0);
    run_unload(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
